scan_bus_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer in front of the SRAM/register scan mux. It shares the single scan access port between requester 0 (scan-chain read/write controller) and requester 1 (SIMD lane loader). Each granted access is issued as a one-cycle strobe with address and data held stable until the mux reports ready. A wait-cycle timeout prevents a dead target from hanging the port.

---
 rtl/scan_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_scan_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_bus_arbiter.sv
// Two-requester round-robin arbiter sequencing accesses onto the shared scan mux port.
// Each access: one-cycle strobe, address/data held until scan_ready or wait timeout.
module scan_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_ren,
   input  logic        req0_wen,
   input  logic [15:0] req0_addr,
   input  logic [15:0] req0_wdata,
   output logic [15:0] req0_rdata,
   output logic        req0_ready,
   output logic        req0_err,
   input  logic        req1_ren,
   input  logic        req1_wen,
   input  logic [15:0] req1_addr,
   input  logic [15:0] req1_wdata,
   output logic [15:0] req1_rdata,
   output logic        req1_ready,
   output logic        req1_err,
   output logic        scan_ren,
   output logic        scan_wen,
   output logic [15:0] scan_addr,
   output logic [15:0] scan_wdata,
   input  logic [15:0] scan_rdata,
   input  logic        scan_ready,
   output logic [1:0]  grant,
   output logic        busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t           state;
   logic             ptr;
   logic             owner;
   logic             op_wr;
   logic [CNT_W-1:0] wait_cnt;

   logic pend0, pend1, pick1, pick_wr;
   logic fin_ok, fin_to;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      pend0   = req0_ren | req0_wen;
      pend1   = req1_ren | req1_wen;
      pick1   = pend1 & (~pend0 | ptr);
      pick_wr = pick1 ? req1_wen : req0_wen;
      fin_ok  = ((state == S_ISSUE) || (state == S_WAIT)) && scan_ready;
      fin_to  = (state == S_WAIT) && !scan_ready && (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_MAX);
   end

   assign busy  = (state != S_IDLE);
   assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override defaults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         op_wr      <= 1'b0;
         wait_cnt   <= '0;
         scan_ren   <= 1'b0;
         scan_wen   <= 1'b0;
         scan_addr  <= 16'h0000;
         scan_wdata <= 16'h0000;
         req0_rdata <= 16'h0000;
         req1_rdata <= 16'h0000;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         req0_err   <= 1'b0;
         req1_err   <= 1'b0;
      end else begin
         scan_ren   <= 1'b0;
         scan_wen   <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         req0_err   <= 1'b0;
         req1_err   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pend0 || pend1) begin
                  owner      <= pick1;
                  op_wr      <= pick_wr;
                  scan_addr  <= pick1 ? req1_addr : req0_addr;
                  scan_wdata <= pick1 ? req1_wdata : req0_wdata;
                  scan_wen   <= pick_wr;
                  scan_ren   <= ~pick_wr;
                  wait_cnt   <= '0;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT:  wait_cnt <= wait_cnt + 1'b1;
            S_DONE: begin
               ptr   <= ~ptr;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Completion overrides the ISSUE/WAIT defaults above.
         if (fin_ok || fin_to) begin
            state <= S_DONE;
            if (owner) begin
               req1_ready <= 1'b1;
               req1_err   <= fin_to;
               req1_rdata <= (fin_ok && !op_wr) ? scan_rdata : 16'h0000;
            end else begin
               req0_ready <= 1'b1;
               req0_err   <= fin_to;
               req0_rdata <= (fin_ok && !op_wr) ? scan_rdata : 16'h0000;
            end
         end
      end
   end

endmodule

// File: tb/tb_scan_bus_arbiter.sv
// Directed self-checking bench for scan_bus_arbiter (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_scan_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_ren, req0_wen, req1_ren, req1_wen;
   logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
   logic [15:0] req0_rdata, req1_rdata;
   logic        req0_ready, req1_ready, req0_err, req1_err;
   logic        scan_ren, scan_wen;
   logic [15:0] scan_addr, scan_wdata, scan_rdata;
   logic        scan_ready;
   logic [1:0]  grant;
   logic        busy;

   int checks = 0;
   int errors = 0;

   scan_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_ren   (req0_ren),
      .req0_wen   (req0_wen),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_rdata (req0_rdata),
      .req0_ready (req0_ready),
      .req0_err   (req0_err),
      .req1_ren   (req1_ren),
      .req1_wen   (req1_wen),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_rdata (req1_rdata),
      .req1_ready (req1_ready),
      .req1_err   (req1_err),
      .scan_ren   (scan_ren),
      .scan_wen   (scan_wen),
      .scan_addr  (scan_addr),
      .scan_wdata (scan_wdata),
      .scan_rdata (scan_rdata),
      .scan_ready (scan_ready),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_g(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      req0_ren = 1'b0; req0_wen = 1'b0;
      req1_ren = 1'b0; req1_wen = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_b({tag, "_busy"},  busy, 1'b0);
      check_g({tag, "_grant"}, grant, 2'b00);
      check_b({tag, "_sren"},  scan_ren, 1'b0);
      check_b({tag, "_swen"},  scan_wen, 1'b0);
      check_w({tag, "_saddr"}, scan_addr, 16'h0000);
      check_w({tag, "_swdat"}, scan_wdata, 16'h0000);
      check_b({tag, "_rdy0"},  req0_ready, 1'b0);
      check_b({tag, "_rdy1"},  req1_ready, 1'b0);
      check_b({tag, "_err0"},  req0_err, 1'b0);
      check_b({tag, "_err1"},  req1_err, 1'b0);
      check_w({tag, "_rdat0"}, req0_rdata, 16'h0000);
      check_w({tag, "_rdat1"}, req1_rdata, 16'h0000);
   endtask

   initial begin
      logic       own;
      logic [1:0] exp_g;

      rst_n = 1'b0;
      drop_reqs();
      req0_addr = 16'h0; req0_wdata = 16'h0;
      req1_addr = 16'h0; req1_wdata = 16'h0;
      scan_rdata = 16'h0; scan_ready = 1'b0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Single zero-wait read from requester 0.
      req0_ren = 1'b1; req0_addr = 16'h0123;
      scan_ready = 1'b1; scan_rdata = 16'hBEEF;
      step();
      check_b("t1_sren", scan_ren, 1'b1);
      check_b("t1_swen", scan_wen, 1'b0);
      check_w("t1_saddr", scan_addr, 16'h0123);
      check_g("t1_grant", grant, 2'b01);
      check_b("t1_busy", busy, 1'b1);
      check_b("t1_rdy0_early", req0_ready, 1'b0);
      step();
      check_b("t1_rdy0", req0_ready, 1'b1);
      check_w("t1_rdat0", req0_rdata, 16'hBEEF);
      check_b("t1_rdy1", req1_ready, 1'b0);
      check_b("t1_sren_off", scan_ren, 1'b0);
      drop_reqs(); scan_ready = 1'b0;
      step();
      check_b("t1_rdy0_off", req0_ready, 1'b0);
      check_b("t1_idle", busy, 1'b0);

      // Write from requester 1, scan_ready four cycles after the strobe.
      req1_wen = 1'b1; req1_addr = 16'h8000; req1_wdata = 16'h5A5A;
      step();
      check_b("t2_swen", scan_wen, 1'b1);
      check_b("t2_sren", scan_ren, 1'b0);
      check_g("t2_grant", grant, 2'b10);
      check_w("t2_saddr", scan_addr, 16'h8000);
      check_w("t2_swdat", scan_wdata, 16'h5A5A);
      for (int c = 2; c <= 5; c++) begin
         step();
         check_b($sformatf("t2_swen_c%0d", c), scan_wen, 1'b0);
         check_w($sformatf("t2_saddr_c%0d", c), scan_addr, 16'h8000);
         check_w($sformatf("t2_swdat_c%0d", c), scan_wdata, 16'h5A5A);
         check_b($sformatf("t2_rdy1_c%0d", c), req1_ready, 1'b0);
         check_b($sformatf("t2_busy_c%0d", c), busy, 1'b1);
         if (c == 5) scan_ready = 1'b1;
      end
      step();
      check_b("t2_rdy1", req1_ready, 1'b1);
      check_b("t2_err1", req1_err, 1'b0);
      check_w("t2_rdat1", req1_rdata, 16'h0000);
      check_b("t2_rdy0", req0_ready, 1'b0);
      check_w("t2_rdat0_kept", req0_rdata, 16'hBEEF);
      drop_reqs(); scan_ready = 1'b0;
      step();

      // Fresh reset, then both requesters held with a zero-wait target.
      rst_n = 1'b0; #2; rst_n = 1'b1;
      step();
      req0_ren = 1'b1; req0_addr = 16'h0011;
      req1_wen = 1'b1; req1_addr = 16'h8022; req1_wdata = 16'h7777;
      scan_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         own = i[0];
         exp_g = own ? 2'b10 : 2'b01;
         scan_rdata = 16'h1000 + 16'(i);
         step();
         check_g($sformatf("t3_grant_%0d", i), grant, exp_g);
         check_b($sformatf("t3_sren_%0d", i), scan_ren, ~own);
         check_b($sformatf("t3_swen_%0d", i), scan_wen, own);
         check_w($sformatf("t3_saddr_%0d", i), scan_addr, own ? 16'h8022 : 16'h0011);
         step();
         check_b($sformatf("t3_rdy0_%0d", i), req0_ready, ~own);
         check_b($sformatf("t3_rdy1_%0d", i), req1_ready, own);
         if (own) check_w($sformatf("t3_rdat1_%0d", i), req1_rdata, 16'h0000);
         else     check_w($sformatf("t3_rdat0_%0d", i), req0_rdata, 16'h1000 + 16'(i));
         step();
         check_b($sformatf("t3_idle_%0d", i), busy, 1'b0);
      end
      drop_reqs(); scan_ready = 1'b0;

      // Timeout on requester 0 followed by a stray late scan_ready.
      scan_rdata = 16'hFFFF;
      req0_ren = 1'b1; req0_addr = 16'h0042;
      step();
      check_b("t4_sren", scan_ren, 1'b1);
      for (int c = 2; c <= 6; c++) begin
         step();
         check_b($sformatf("t4_rdy0_c%0d", c), req0_ready, 1'b0);
         check_b($sformatf("t4_busy_c%0d", c), busy, 1'b1);
         check_w($sformatf("t4_saddr_c%0d", c), scan_addr, 16'h0042);
      end
      step();
      check_b("t4_rdy0", req0_ready, 1'b1);
      check_b("t4_err0", req0_err, 1'b1);
      check_w("t4_rdat0", req0_rdata, 16'h0000);
      check_b("t4_rdy1", req1_ready, 1'b0);
      drop_reqs();
      step();
      check_b("t4_rdy0_off", req0_ready, 1'b0);
      check_b("t4_err0_off", req0_err, 1'b0);
      check_b("t4_idle", busy, 1'b0);
      step();
      scan_ready = 1'b1;
      step();
      check_b("t4_late_busy", busy, 1'b0);
      check_g("t4_late_grant", grant, 2'b00);
      check_b("t4_late_rdy0", req0_ready, 1'b0);
      check_b("t4_late_rdy1", req1_ready, 1'b0);
      check_b("t4_late_sren", scan_ren, 1'b0);
      scan_ready = 1'b0;

      // Reset asserted in WAIT, then pointer must be back at requester 0.
      req1_ren = 1'b1; req1_addr = 16'h8100;
      step();
      check_g("t5_grant", grant, 2'b10);
      check_b("t5_sren", scan_ren, 1'b1);
      step();
      check_b("t5_wait_busy", busy, 1'b1);
      check_b("t5_wait_sren", scan_ren, 1'b0);
      #2; rst_n = 1'b0;
      #1;
      check_all_zero("t5_rst");
      rst_n = 1'b1;
      req0_ren = 1'b1; req0_addr = 16'h0200;
      scan_ready = 1'b1; scan_rdata = 16'hCAFE;
      step();
      check_g("t5_grant0", grant, 2'b01);
      check_b("t5_sren0", scan_ren, 1'b1);
      check_w("t5_saddr0", scan_addr, 16'h0200);
      check_b("t5_rdy1_none", req1_ready, 1'b0);
      step();
      check_b("t5_rdy0", req0_ready, 1'b1);
      check_w("t5_rdat0", req0_rdata, 16'hCAFE);
      check_b("t5_rdy1", req1_ready, 1'b0);
      req0_ren = 1'b0;
      step();
      check_b("t5_idle", busy, 1'b0);
      step();
      check_g("t5_grant1", grant, 2'b10);
      check_w("t5_saddr1", scan_addr, 16'h8100);
      step();
      check_b("t5_rdy1_done", req1_ready, 1'b1);
      check_w("t5_rdat1", req1_rdata, 16'hCAFE);
      drop_reqs();
      step();

      // ren and wen both high on requester 0: treated as a write.
      req0_ren = 1'b1; req0_wen = 1'b1;
      req0_addr = 16'h0007; req0_wdata = 16'hA5A5;
      scan_rdata = 16'h1357;
      step();
      check_b("t6_swen", scan_wen, 1'b1);
      check_b("t6_sren", scan_ren, 1'b0);
      check_w("t6_swdat", scan_wdata, 16'hA5A5);
      step();
      check_b("t6_rdy0", req0_ready, 1'b1);
      check_w("t6_rdat0", req0_rdata, 16'h0000);
      check_b("t6_sren_off", scan_ren, 1'b0);
      drop_reqs(); scan_ready = 1'b0;
      step();
      check_b("t6_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
